dcache_nway_sram: RTL and testbench

DCACHE_NWAY_SRAM -- requirements
Module: dcache_nway_sram

---
 rtl/dcache_nway_sram.sv | 127 ++++++++++++
 tb/tb_dcache_nway_sram.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway_sram.sv
// N-way set-associative data cache array with per-set true-LRU ages.
// Combinational lookup and victim selection; all state updates on the rising edge of clk_i.
module dcache_nway_sram #(
  parameter int SETS   = 16,
  parameter int WAYS   = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              dirty_i,
  input  logic              inval_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [AGE_W-1:0]  way_o
);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] line_q  [SETS][WAYS];

  logic             hit_any, inv_any, hit;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim_way, sel_way;
  logic             do_access, touch, write_line;
  logic [AGE_W-1:0] age_nxt [WAYS];

  // Scanning from the top down leaves the lowest matching index in each result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[addr_i][w]) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(w);
      end
      if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) begin
        lru_way = AGE_W'(w);
      end
    end
  end

  assign victim_way = inv_any ? inv_way : lru_way;
  assign hit        = enable_i & ~inval_i & ~rst_i & hit_any;
  // Reset forces way 0, which is the lowest invalid way once reset has taken effect.
  assign sel_way    = rst_i ? '0 : (hit ? hit_way : victim_way);

  assign hit_o   = hit;
  assign way_o   = sel_way;
  assign data_o  = line_q[addr_i][sel_way];
  assign tag_o   = tag_q[addr_i][sel_way];
  assign valid_o = ~rst_i & valid_q[addr_i][sel_way];
  assign dirty_o = ~rst_i & dirty_q[addr_i][sel_way];

  // A read miss leaves everything alone; hits and fills both refresh recency.
  assign do_access  = ~rst_i & ~inval_i & enable_i;
  assign touch      = do_access & (hit_any | write_i);
  assign write_line = do_access & write_i;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == sel_way) begin
        age_nxt[w] = '0;
      end else if (age_q[addr_i][w] < age_q[addr_i][sel_way]) begin
        age_nxt[w] = age_q[addr_i][w] + AGE_W'(1);
      end else begin
        age_nxt[w] = age_q[addr_i][w];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else if (inval_i) begin
      valid_q[addr_i] <= '0;
      dirty_q[addr_i] <= '0;
    end else begin
      if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[addr_i][w] <= age_nxt[w];
        end
      end
      if (write_line) begin
        valid_q[addr_i][sel_way] <= 1'b1;
        dirty_q[addr_i][sel_way] <= dirty_i;
      end
    end
  end

  // NOTE: tag and line storage is deliberately left out of reset; valid bits guard it.
  always_ff @(posedge clk_i) begin
    if (write_line) begin
      line_q[addr_i][sel_way] <= data_i;
      if (!hit_any) begin
        tag_q[addr_i][sel_way] <= tag_i;
      end
    end
  end

endmodule

// File: tb/tb_dcache_nway_sram.sv
// Bench for dcache_nway_sram: four configurations driven in parallel and checked every cycle
// against a recency-list reference model, plus directed literal scenarios on the default config.
module tb_dcache_nway_sram;

  localparam int TW = 23;
  localparam int LW = 256;
  localparam int NC = 4;
  localparam int cfg_ways [NC] = '{4, 1, 2, 8};
  localparam int cfg_sets [NC] = '{16, 2, 2, 2};

  logic          clk = 1'b0;
  logic          rst, inval, en, wr, dt;
  logic [3:0]    addr;
  logic [TW-1:0] tag;
  logic [LW-1:0] data;

  always #5 clk = ~clk;

  logic          hit0, valid0, dirty0, hit1, valid1, dirty1;
  logic          hit2, valid2, dirty2, hit3, valid3, dirty3;
  logic [LW-1:0] data0, data1, data2, data3;
  logic [TW-1:0] tag0, tag1, tag2, tag3;
  logic [1:0]    way0;
  logic [0:0]    way1, way2;
  logic [2:0]    way3;

  dcache_nway_sram #(.SETS(16), .WAYS(4), .TAG_W(TW), .LINE_W(LW)) u_c0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .tag_i(tag), .data_i(data), .enable_i(en),
    .write_i(wr), .dirty_i(dt), .inval_i(inval), .hit_o(hit0), .data_o(data0), .tag_o(tag0),
    .valid_o(valid0), .dirty_o(dirty0), .way_o(way0));
  dcache_nway_sram #(.SETS(2), .WAYS(1), .TAG_W(TW), .LINE_W(LW)) u_c1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0:0]), .tag_i(tag), .data_i(data), .enable_i(en),
    .write_i(wr), .dirty_i(dt), .inval_i(inval), .hit_o(hit1), .data_o(data1), .tag_o(tag1),
    .valid_o(valid1), .dirty_o(dirty1), .way_o(way1));
  dcache_nway_sram #(.SETS(2), .WAYS(2), .TAG_W(TW), .LINE_W(LW)) u_c2 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0:0]), .tag_i(tag), .data_i(data), .enable_i(en),
    .write_i(wr), .dirty_i(dt), .inval_i(inval), .hit_o(hit2), .data_o(data2), .tag_o(tag2),
    .valid_o(valid2), .dirty_o(dirty2), .way_o(way2));
  dcache_nway_sram #(.SETS(2), .WAYS(8), .TAG_W(TW), .LINE_W(LW)) u_c3 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0:0]), .tag_i(tag), .data_i(data), .enable_i(en),
    .write_i(wr), .dirty_i(dt), .inval_i(inval), .hit_o(hit3), .data_o(data3), .tag_o(tag3),
    .valid_o(valid3), .dirty_o(dirty3), .way_o(way3));

  logic          a_hit [NC], a_valid [NC], a_dirty [NC];
  logic [2:0]    a_way [NC];
  logic [LW-1:0] a_data [NC];
  logic [TW-1:0] a_tag [NC];

  always_comb begin
    a_hit[0] = hit0;  a_valid[0] = valid0; a_dirty[0] = dirty0; a_way[0] = 3'(way0);
    a_hit[1] = hit1;  a_valid[1] = valid1; a_dirty[1] = dirty1; a_way[1] = 3'(way1);
    a_hit[2] = hit2;  a_valid[2] = valid2; a_dirty[2] = dirty2; a_way[2] = 3'(way2);
    a_hit[3] = hit3;  a_valid[3] = valid3; a_dirty[3] = dirty3; a_way[3] = 3'(way3);
    a_data[0] = data0; a_data[1] = data1; a_data[2] = data2; a_data[3] = data3;
    a_tag[0] = tag0;   a_tag[1] = tag1;   a_tag[2] = tag2;   a_tag[3] = tag3;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per set, a recency list of way numbers (most recent first).
  bit            m_valid [NC][16][8];
  bit            m_dirty [NC][16][8];
  bit            m_known [NC][16][8];
  logic [TW-1:0] m_tag   [NC][16][8];
  logic [LW-1:0] m_line  [NC][16][8];
  int            m_order [NC][16][8];
  bit            cmp_on = 1'b0;

  task automatic model_touch(input int c, input int s, input int w);
    int p = 0;
    for (int i = 0; i < cfg_ways[c]; i++) if (m_order[c][s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_order[c][s][i] = m_order[c][s][i-1];
    m_order[c][s][0] = w;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int c = 0; c < NC; c++) begin
        int  s, nw, hw, vic, sel;
        bit  e_hit;
        s  = int'(addr) % cfg_sets[c];
        nw = cfg_ways[c];
        hw = -1;
        vic = -1;
        for (int w = nw - 1; w >= 0; w--) begin
          if (m_valid[c][s][w] && m_tag[c][s][w] == tag) hw = w;
          if (!m_valid[c][s][w]) vic = w;
        end
        if (vic < 0) vic = m_order[c][s][nw-1];
        e_hit = !rst && !inval && en && (hw >= 0);
        sel   = rst ? 0 : (e_hit ? hw : vic);
        check($sformatf("c%0d_hit", c), a_hit[c], e_hit);
        check($sformatf("c%0d_way", c), a_way[c], sel);
        check($sformatf("c%0d_valid", c), a_valid[c], rst ? 1'b0 : m_valid[c][s][sel]);
        check($sformatf("c%0d_dirty", c), a_dirty[c], rst ? 1'b0 : m_dirty[c][s][sel]);
        if (!rst && m_known[c][s][sel]) begin
          check($sformatf("c%0d_tag", c), a_tag[c], m_tag[c][s][sel]);
          check($sformatf("c%0d_data", c), a_data[c], m_line[c][s][sel]);
        end
        // Advance the model with the inputs the DUT will see at the next rising edge.
        if (rst) begin
          for (int ss = 0; ss < 16; ss++)
            for (int w = 0; w < 8; w++) begin
              m_valid[c][ss][w] = 1'b0;
              m_dirty[c][ss][w] = 1'b0;
              m_order[c][ss][w] = w;
            end
        end else if (inval) begin
          for (int w = 0; w < 8; w++) begin
            m_valid[c][s][w] = 1'b0;
            m_dirty[c][s][w] = 1'b0;
          end
        end else if (en) begin
          if (hw >= 0) begin
            if (wr) begin
              m_line[c][s][hw]  = data;
              m_dirty[c][s][hw] = dt;
            end
            model_touch(c, s, hw);
          end else if (wr) begin
            m_tag[c][s][vic]   = tag;
            m_line[c][s][vic]  = data;
            m_valid[c][s][vic] = 1'b1;
            m_dirty[c][s][vic] = dt;
            m_known[c][s][vic] = 1'b1;
            model_touch(c, s, vic);
          end
        end
      end
    end
  end

  task automatic op(input logic r, input logic iv, input logic e, input logic w, input logic d,
                    input logic [3:0] a, input logic [TW-1:0] t, input logic [LW-1:0] l);
    @(posedge clk);
    #1;
    rst = r; inval = iv; en = e; wr = w; dt = d; addr = a; tag = t; data = l;
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  localparam logic [LW-1:0] D1 = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] D2 = {8{32'h5A5A_0002}};
  localparam logic [LW-1:0] D3 = {8{32'h1234_0003}};

  initial begin
    rst = 1'b1; inval = 1'b0; en = 1'b0; wr = 1'b0; dt = 1'b0;
    addr = '0; tag = '0; data = '0;
    cmp_on = 1'b1;

    // Reset state
    op(1, 0, 1, 0, 0, 4'd3, 23'h11, '0);
    check("rst_hit", hit0, 1'b0);
    check("rst_valid", valid0, 1'b0);
    check("rst_way", way0, 2'd0);
    op(1, 0, 0, 0, 0, 4'd0, 23'h0, '0);

    // Miss, fill, then hit in set 3
    op(0, 0, 1, 0, 0, 4'd3, 23'h11, '0);
    check("s3_miss_hit", hit0, 1'b0);
    check("s3_miss_way", way0, 2'd0);
    check("s3_miss_valid", valid0, 1'b0);
    op(0, 0, 1, 1, 0, 4'd3, 23'h11, D1);
    op(0, 0, 1, 0, 0, 4'd3, 23'h11, '0);
    check("s3_hit", hit0, 1'b1);
    check("s3_hit_data", data0, D1);
    check("s3_hit_way", way0, 2'd0);

    // LRU replacement in set 5: A,B,C,D then read A; E must evict B in way 1
    op(0, 0, 1, 1, 0, 4'd5, 23'hA0, rand_line());
    check("s5_fillA_way", way0, 2'd0);
    op(0, 0, 1, 1, 1, 4'd5, 23'hB0, rand_line());
    check("s5_fillB_way", way0, 2'd1);
    op(0, 0, 1, 1, 0, 4'd5, 23'hC0, rand_line());
    op(0, 0, 1, 1, 0, 4'd5, 23'hD0, rand_line());
    check("s5_fillD_way", way0, 2'd3);
    op(0, 0, 1, 0, 0, 4'd5, 23'hA0, '0);
    check("s5_readA_hit", hit0, 1'b1);
    op(0, 0, 1, 0, 0, 4'd5, 23'hE0, '0);
    check("s5_missE_hit", hit0, 1'b0);
    check("s5_missE_way", way0, 2'd1);
    check("s5_missE_tag", tag0, 23'hB0);
    check("s5_missE_valid", valid0, 1'b1);
    check("s5_missE_dirty", dirty0, 1'b1);
    op(0, 0, 1, 1, 0, 4'd5, 23'hE0, D3);
    op(0, 0, 1, 0, 0, 4'd5, 23'hE0, '0);
    check("s5_readE_hit", hit0, 1'b1);
    check("s5_readE_way", way0, 2'd1);

    // Write hit marks a clean line dirty; it resurfaces as victim after three newer fills
    op(0, 0, 1, 1, 1, 4'd3, 23'h11, D2);
    check("s3_wrhit_hit", hit0, 1'b1);
    op(0, 0, 1, 1, 0, 4'd3, 23'h12, rand_line());
    op(0, 0, 1, 1, 0, 4'd3, 23'h13, rand_line());
    op(0, 0, 1, 1, 0, 4'd3, 23'h14, rand_line());
    op(0, 0, 1, 0, 0, 4'd3, 23'h99, '0);
    check("s3_vic_way", way0, 2'd0);
    check("s3_vic_dirty", dirty0, 1'b1);
    check("s3_vic_valid", valid0, 1'b1);
    check("s3_vic_data", data0, D2);

    // Invalidate takes priority over a hitting access
    op(0, 1, 1, 0, 0, 4'd5, 23'hE0, '0);
    check("inval_hit", hit0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] tags [4] = '{8'hA0, 8'hE0, 8'hC0, 8'hD0};
      op(0, 0, 1, 0, 0, 4'd5, 23'(tags[i]), '0);
      check("post_inval_hit", hit0, 1'b0);
      check("post_inval_way", way0, 2'd0);
      check("post_inval_valid", valid0, 1'b0);
    end

    // Reset drops a fill issued in the same cycle
    op(1, 0, 1, 1, 1, 4'd7, 23'h55, D3);
    check("rst_fill_hit", hit0, 1'b0);
    check("rst_fill_way", way0, 2'd0);
    op(0, 0, 1, 0, 0, 4'd7, 23'h55, '0);
    check("after_rst_hit", hit0, 1'b0);
    check("after_rst_way", way0, 2'd0);
    check("after_rst_valid", valid0, 1'b0);

    // Randomized traffic on all four configurations
    for (int i = 0; i < 3000; i++) begin
      logic          r_r, r_iv, r_en, r_wr, r_dt;
      logic [TW-1:0] r_t;
      r_r  = ($urandom_range(0, 999) < 3);
      r_iv = ($urandom_range(0, 99) < 3);
      r_en = ($urandom_range(0, 99) < 85);
      r_wr = $urandom_range(0, 1);
      r_dt = $urandom_range(0, 1);
      r_t  = ($urandom_range(0, 19) == 0) ? TW'($urandom) : TW'($urandom_range(0, 11));
      op(r_r, r_iv, r_en, r_wr, r_dt, 4'($urandom_range(0, 15)), r_t, rand_line());
    end

    op(0, 0, 0, 0, 0, 4'd0, 23'h0, '0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
